// File: rtl/sequenciador_batalha.sv
// Game sequencer for the 5x7 battleship board: power-on, placement, saving
// the fleet, attack turns, victory/defeat, attack map and counters.
module sequenciador_batalha #(
    parameter int MAX_TENTATIVAS = 15,
    parameter int LARGURA_CONT   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ligado,
    input  logic                    modo,
    input  logic                    salvar_jogo,
    input  logic                    confirmar_ataque,
    input  logic [2:0]              ataque_colunas,
    input  logic [2:0]              ataque_linhas,
    input  logic [6:0]              coluna1_posicionamento,
    input  logic [6:0]              coluna2_posicionamento,
    input  logic [6:0]              coluna3_posicionamento,
    input  logic [6:0]              coluna4_posicionamento,
    input  logic [6:0]              coluna5_posicionamento,
    output logic [6:0]              coluna1_saida,
    output logic [6:0]              coluna2_saida,
    output logic [6:0]              coluna3_saida,
    output logic [6:0]              coluna4_saida,
    output logic [6:0]              coluna5_saida,
    output logic                    led_acerto,
    output logic                    led_erro,
    output logic                    led_vitoria,
    output logic                    led_derrota,
    output logic [LARGURA_CONT-1:0] tentativas_restantes,
    output logic [5:0]              navios_restantes
);

    typedef enum logic [2:0] {
        DESLIGADO,
        POSICIONAMENTO,
        ATAQUE,
        VITORIA,
        DERROTA
    } estado_t;

    estado_t estado, estado_prox;

    // Column c of the board lives at index c-1; bit r-1 is row r (0 = ship).
    logic [4:0][6:0] posicionamento;
    logic [4:0][6:0] tabuleiro;
    logic [4:0][6:0] mapa;
    logic [4:0][6:0] saida;
    logic            salvo;
    logic            salvar_ant;
    logic            confirmar_ant;

    logic                    salvar_borda;
    logic                    confirmar_borda;
    logic [2:0]              col_idx;
    logic [2:0]              lin_idx;
    logic                    coord_valida;
    logic                    ja_atacado;
    logic                    eh_navio;
    logic                    ataque_ok;
    logic [5:0]              navios_novo;
    logic [LARGURA_CONT-1:0] tent_novo;

    // Number of ship cells (zero bits) on a board.
    function automatic logic [5:0] conta_navios(input logic [4:0][6:0] t);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 7; j++) begin
                n = n + {5'd0, ~t[i][j]};
            end
        end
        return n;
    endfunction

    assign posicionamento = {coluna5_posicionamento, coluna4_posicionamento,
                             coluna3_posicionamento, coluna2_posicionamento,
                             coluna1_posicionamento};

    // Button edges, attack decode and the counter values a valid attack produces.
    always_comb begin
        salvar_borda    = salvar_jogo & ~salvar_ant;
        confirmar_borda = confirmar_ataque & ~confirmar_ant;
        col_idx         = ataque_colunas - 3'd1;
        lin_idx         = ataque_linhas - 3'd1;
        coord_valida    = (ataque_colunas >= 3'd1) && (ataque_colunas <= 3'd5) &&
                          (ataque_linhas != 3'd0);
        ja_atacado      = 1'b0;
        eh_navio        = 1'b0;
        if (coord_valida) begin
            ja_atacado = mapa[col_idx][lin_idx];
            eh_navio   = ~tabuleiro[col_idx][lin_idx];
        end
        ataque_ok   = (estado == ATAQUE) && ligado && modo && confirmar_borda &&
                      coord_valida && !ja_atacado;
        navios_novo = (eh_navio && navios_restantes != 6'd0) ?
                      navios_restantes - 6'd1 : navios_restantes;
        tent_novo   = (tentativas_restantes != '0) ?
                      tentativas_restantes - 1'b1 : tentativas_restantes;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) estado <= DESLIGADO;
        else          estado <= estado_prox;
    end

    // Next-state logic; power-off overrides every other event.
    always_comb begin
        estado_prox = estado;
        if (!ligado) begin
            estado_prox = DESLIGADO;
        end else begin
            case (estado)
                DESLIGADO:      estado_prox = POSICIONAMENTO;
                POSICIONAMENTO: if (!salvar_borda && modo && salvo) estado_prox = ATAQUE;
                ATAQUE: begin
                    if (!modo) begin
                        estado_prox = POSICIONAMENTO;
                    end else if (ataque_ok) begin
                        if (navios_novo == 6'd0)     estado_prox = VITORIA;
                        else if (tent_novo == '0)    estado_prox = DERROTA;
                    end
                end
                VITORIA, DERROTA: if (!modo) estado_prox = POSICIONAMENTO;
                default:        estado_prox = DESLIGADO;
            endcase
        end
    end

    // Saved board, attack map, counters, hit/miss LEDs and button history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tabuleiro            <= '1;
            salvo                <= 1'b0;
            mapa                 <= '0;
            tentativas_restantes <= '0;
            navios_restantes     <= '0;
            led_acerto           <= 1'b0;
            led_erro             <= 1'b0;
            salvar_ant           <= 1'b0;
            confirmar_ant        <= 1'b0;
        end else begin
            salvar_ant    <= salvar_jogo;
            confirmar_ant <= confirmar_ataque;
            if (!ligado) begin
                tabuleiro            <= '1;
                salvo                <= 1'b0;
                mapa                 <= '0;
                tentativas_restantes <= '0;
                navios_restantes     <= '0;
                led_acerto           <= 1'b0;
                led_erro             <= 1'b0;
            end else begin
                case (estado)
                    POSICIONAMENTO: begin
                        if (salvar_borda) begin
                            tabuleiro        <= posicionamento;
                            navios_restantes <= conta_navios(posicionamento);
                            salvo            <= (conta_navios(posicionamento) != 6'd0);
                        end else if (modo && salvo) begin
                            tentativas_restantes <= LARGURA_CONT'(MAX_TENTATIVAS);
                            navios_restantes     <= conta_navios(tabuleiro);
                            mapa                 <= '0;
                            led_acerto           <= 1'b0;
                            led_erro             <= 1'b0;
                        end
                    end
                    ATAQUE, VITORIA, DERROTA: begin
                        if (!modo) begin
                            mapa                 <= '0;
                            tentativas_restantes <= '0;
                            led_acerto           <= 1'b0;
                            led_erro             <= 1'b0;
                        end else if (ataque_ok) begin
                            mapa[col_idx][lin_idx] <= 1'b1;
                            tentativas_restantes   <= tent_novo;
                            navios_restantes       <= navios_novo;
                            led_acerto             <= eh_navio;
                            led_erro               <= ~eh_navio;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // LED matrix drive: placement passes through, attack shows hits, end shows the fleet.
    always_comb begin
        saida = '1;
        case (estado)
            POSICIONAMENTO:   saida = (modo && !salvo) ? '1 : posicionamento;
            ATAQUE:           saida = ~mapa | tabuleiro;
            VITORIA, DERROTA: saida = tabuleiro;
            default:          saida = '1;
        endcase
    end

    assign coluna1_saida = saida[0];
    assign coluna2_saida = saida[1];
    assign coluna3_saida = saida[2];
    assign coluna4_saida = saida[3];
    assign coluna5_saida = saida[4];
    assign led_vitoria   = (estado == VITORIA);
    assign led_derrota   = (estado == DERROTA);

endmodule

// File: tb/tb_sequenciador_batalha.sv
// Bench for sequenciador_batalha: default instance plus a 2-attempt instance.
module tb_sequenciador_batalha;

    typedef struct packed {
        logic [4:0][6:0] col;
        logic            ac;
        logic            er;
        logic            vi;
        logic            de;
        logic [3:0]      te;
        logic [5:0]      na;
    } snap_t;

    logic clock, reset_n, ligado, modo, salvar, confirmar;
    logic [2:0] ataque_colunas, ataque_linhas;
    logic [4:0][6:0] pos;
    logic [4:0][6:0] sa1, sa2;
    logic ac1, er1, vi1, de1, ac2, er2, vi2, de2;
    logic [3:0] te1, te2;
    logic [5:0] na1, na2;
    snap_t s1, s2, e;
    snap_t exp_q[$];
    int n_err, n_chk;
    logic [4:0][6:0] TAB, TAB2, VAZIO, TMP;

    assign s1 = {sa1, ac1, er1, vi1, de1, te1, na1};
    assign s2 = {sa2, ac2, er2, vi2, de2, te2, na2};

    sequenciador_batalha dut (
        .clock(clock), .reset_n(reset_n), .ligado(ligado), .modo(modo),
        .salvar_jogo(salvar), .confirmar_ataque(confirmar),
        .ataque_colunas(ataque_colunas), .ataque_linhas(ataque_linhas),
        .coluna1_posicionamento(pos[0]), .coluna2_posicionamento(pos[1]),
        .coluna3_posicionamento(pos[2]), .coluna4_posicionamento(pos[3]),
        .coluna5_posicionamento(pos[4]),
        .coluna1_saida(sa1[0]), .coluna2_saida(sa1[1]), .coluna3_saida(sa1[2]),
        .coluna4_saida(sa1[3]), .coluna5_saida(sa1[4]),
        .led_acerto(ac1), .led_erro(er1), .led_vitoria(vi1), .led_derrota(de1),
        .tentativas_restantes(te1), .navios_restantes(na1)
    );

    sequenciador_batalha #(.MAX_TENTATIVAS(2), .LARGURA_CONT(4)) dut2 (
        .clock(clock), .reset_n(reset_n), .ligado(ligado), .modo(modo),
        .salvar_jogo(salvar), .confirmar_ataque(confirmar),
        .ataque_colunas(ataque_colunas), .ataque_linhas(ataque_linhas),
        .coluna1_posicionamento(pos[0]), .coluna2_posicionamento(pos[1]),
        .coluna3_posicionamento(pos[2]), .coluna4_posicionamento(pos[3]),
        .coluna5_posicionamento(pos[4]),
        .coluna1_saida(sa2[0]), .coluna2_saida(sa2[1]), .coluna3_saida(sa2[2]),
        .coluna4_saida(sa2[3]), .coluna5_saida(sa2[4]),
        .led_acerto(ac2), .led_erro(er2), .led_vitoria(vi2), .led_derrota(de2),
        .tentativas_restantes(te2), .navios_restantes(na2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic snap_t mk(input logic [4:0][6:0] c, input logic a, input logic r,
                                 input logic v, input logic d, input logic [3:0] t,
                                 input logic [5:0] n);
        return {c, a, r, v, d, t, n};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press_save();
        salvar = 1'b1;
        tick();
        salvar = 1'b0;
        tick();
    endtask

    task automatic atacar(input logic [2:0] c, input logic [2:0] r, input int hold);
        ataque_colunas = c;
        ataque_linhas  = r;
        confirmar      = 1'b1;
        repeat (hold) tick();
        confirmar = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ligado = 1'b0; modo = 1'b0; salvar = 1'b0; confirmar = 1'b0;
        ataque_colunas = 3'd0; ataque_linhas = 3'd0; pos = TAB;
        exp_q.push_back(mk(VAZIO, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0));
        exp_q.push_back(mk(VAZIO, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0));
        tick(); tick();
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL reset_dut: got %h expected %h", s1, e); end
        e = exp_q.pop_front(); n_chk++;
        if (s2 !== e) begin n_err++; $display("FAIL reset_dut2: got %h expected %h", s2, e); end
        reset_n = 1'b1;
    endtask

    task automatic test_placement();
        ligado = 1'b1;
        exp_q.push_back(mk(TAB, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0));
        tick();
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL place_follow: got %h expected %h", s1, e); end
        TMP = TAB; TMP[1] = 7'h55;
        exp_q.push_back(mk(TMP, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0));
        pos[1] = 7'h55;
        #1;
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL place_comb: got %h expected %h", s1, e); end
        pos[1] = 7'h7F;
        #1;
    endtask

    task automatic test_save_enter();
        exp_q.push_back(mk(TAB, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd2));
        press_save();
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL save: got %h expected %h", s1, e); end
        exp_q.push_back(mk(VAZIO, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 6'd2));
        modo = 1'b1;
        tick();
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL enter_attack: got %h expected %h", s1, e); end
    endtask

    task automatic test_attack();
        TMP = VAZIO; TMP[0] = 7'b1111110;
        exp_q.push_back(mk(TMP, 1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 6'd1));
        atacar(3'd1, 3'd1, 1);
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL hit_1_1: got %h expected %h", s1, e); end
        exp_q.push_back(mk(TMP, 1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 6'd1));
        atacar(3'd1, 3'd1, 1);
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL repeat_1_1: got %h expected %h", s1, e); end
        exp_q.push_back(mk(TMP, 1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 6'd1));
        atacar(3'd6, 3'd2, 1);
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL invalid_col6: got %h expected %h", s1, e); end
        exp_q.push_back(mk(TMP, 1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 6'd1));
        atacar(3'd2, 3'd0, 1);
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL invalid_row0: got %h expected %h", s1, e); end
        exp_q.push_back(mk(TMP, 1'b0, 1'b1, 1'b0, 1'b0, 4'd13, 6'd1));
        atacar(3'd2, 3'd2, 3);
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL miss_held: got %h expected %h", s1, e); end
        exp_q.push_back(mk(TAB, 1'b1, 1'b0, 1'b1, 1'b0, 4'd12, 6'd0));
        atacar(3'd3, 3'd4, 1);
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL victory: got %h expected %h", s1, e); end
        exp_q.push_back(mk(TAB, 1'b1, 1'b0, 1'b1, 1'b0, 4'd12, 6'd0));
        atacar(3'd5, 3'd5, 1);
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL confirm_in_victory: got %h expected %h", s1, e); end
    endtask

    task automatic test_modo_return();
        exp_q.push_back(mk(TAB, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0));
        modo = 1'b0;
        tick();
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL back_to_place: got %h expected %h", s1, e); end
        exp_q.push_back(mk(VAZIO, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 6'd2));
        modo = 1'b1;
        tick();
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL reenter_attack: got %h expected %h", s1, e); end
    endtask

    task automatic test_power_off();
        atacar(3'd1, 3'd1, 1);
        exp_q.push_back(mk(VAZIO, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0));
        ligado = 1'b0;
        tick();
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL power_off: got %h expected %h", s1, e); end
        exp_q.push_back(mk(VAZIO, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0));
        ligado = 1'b1;
        tick(); tick(); tick();
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL attack_without_save: got %h expected %h", s1, e); end
        pos = VAZIO; modo = 1'b0;
        tick();
        press_save();
        exp_q.push_back(mk(VAZIO, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0));
        modo = 1'b1;
        tick(); tick();
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL empty_save_rejected: got %h expected %h", s1, e); end
    endtask

    task automatic test_defeat();
        reset_n = 1'b0; ligado = 1'b0; modo = 1'b0;
        tick();
        reset_n = 1'b1; ligado = 1'b1; pos = TAB2;
        tick();
        press_save();
        exp_q.push_back(mk(VAZIO, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 6'd1));
        modo = 1'b1;
        tick();
        e = exp_q.pop_front(); n_chk++;
        if (s2 !== e) begin n_err++; $display("FAIL small_enter: got %h expected %h", s2, e); end
        exp_q.push_back(mk(TAB2, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 6'd1));
        atacar(3'd1, 3'd1, 1);
        atacar(3'd2, 3'd2, 1);
        e = exp_q.pop_front(); n_chk++;
        if (s2 !== e) begin n_err++; $display("FAIL defeat: got %h expected %h", s2, e); end
        exp_q.push_back(mk(TAB2, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 6'd1));
        atacar(3'd5, 3'd7, 1);
        e = exp_q.pop_front(); n_chk++;
        if (s2 !== e) begin n_err++; $display("FAIL confirm_in_defeat: got %h expected %h", s2, e); end
        modo = 1'b0;
        tick();
        modo = 1'b1;
        tick();
        exp_q.push_back(mk(TAB2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 6'd0));
        atacar(3'd1, 3'd1, 1);
        atacar(3'd5, 3'd7, 1);
        e = exp_q.pop_front(); n_chk++;
        if (s2 !== e) begin n_err++; $display("FAIL last_attempt_victory: got %h expected %h", s2, e); end
    endtask

    task automatic test_reset_mid();
        pos = TAB; modo = 1'b0;
        tick();
        press_save();
        modo = 1'b1;
        tick();
        atacar(3'd1, 3'd1, 1);
        exp_q.push_back(mk(VAZIO, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0));
        reset_n = 1'b0;
        #2;
        e = exp_q.pop_front(); n_chk++;
        if (s1 !== e) begin n_err++; $display("FAIL async_reset_mid: got %h expected %h", s1, e); end
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        n_err = 0; n_chk = 0;
        VAZIO = '1;
        TAB = '1; TAB[0] = 7'b1111110; TAB[2] = 7'b1110111;
        TAB2 = '1; TAB2[4] = 7'b0111111;
        test_reset();
        test_placement();
        test_save_enter();
        test_attack();
        test_modo_return();
        test_power_off();
        test_defeat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sequenciador_batalha.md
# sequenciador_batalha

Clocked game sequencer for the 5×7 battleship board. It owns the game flow: power-on, placement, saving the fleet, attack turns, and the end of game. It latches the placement board, scores each confirmed attack against the saved fleet, and keeps an attack map and turn/ship counters. Its column outputs drive the active-low LED matrix, and its status LEDs report hit, miss, victory and defeat.

## Interface
Parameters:
- MAX_TENTATIVAS, default 15: attacks allowed per game.
- LARGURA_CONT, default 4: width of the attempt counter. Must satisfy 2^LARGURA_CONT > MAX_TENTATIVAS.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ligado  in  1  game power switch (level).
- modo  in  1  0 = placement, 1 = attack (level).
- salvar_jogo  in  1  save button; already debounced and synchronous. Acts on its rising edge.
- confirmar_ataque  in  1  attack button; already debounced and synchronous. Acts on its rising edge.
- ataque_colunas  in  3  attacked column, 1..5.
- ataque_linhas  in  3  attacked row, 1..7.
- coluna1_posicionamento … coluna5_posicionamento  in  7 each  placement board. Bit r-1 is row r; 0 = ship.
- coluna1_saida … coluna5_saida  out  7 each  LED matrix drive, active-low.
- led_acerto  out  1  last valid attack hit a ship.
- led_erro  out  1  last valid attack missed.
- led_vitoria  out  1  all ships sunk.
- led_derrota  out  1  attempts exhausted.
- tentativas_restantes  out  LARGURA_CONT  attacks left.
- navios_restantes  out  6  unsunk ship cells, 0..35.

## Operation
- States: DESLIGADO, POSICIONAMENTO, ATAQUE, VITORIA, DERROTA.
- ligado=0 in any state → DESLIGADO at the next edge. This clears:
  - saved board to all ones, and the salvo flag;
  - attack map, counters and LEDs.
  - ligado=0 has priority over every other event in the same cycle.
- DESLIGADO: leaves to POSICIONAMENTO when ligado=1.
- POSICIONAMENTO:
  - coluna*_saida = coluna*_posicionamento.
  - Save edge → latch all 5 columns into the saved board, set navios_restantes to the count of 0 bits, set salvo = (count ≠ 0). An empty board is a rejected save: salvo=0.
  - Saving again overwrites the previous save.
- POSICIONAMENTO → ATAQUE when modo=1 and salvo=1. On entry:
  - tentativas_restantes = MAX_TENTATIVAS;
  - navios_restantes recomputed from the saved board;
  - attack map cleared; led_acerto and led_erro = 0.
- modo=1 with salvo=0: stay in POSICIONAMENTO and drive coluna*_saida = 7'h7F.
- ATAQUE, on a confirm edge:
  - Invalid coordinates (column 0, column 6..7, or row 0) → ignored. Nothing changes.
  - Cell already in the attack map → ignored. The counter is not decremented.
  - Otherwise:
    - set the map bit (column c, bit r-1);
    - decrement tentativas_restantes;
    - if the saved bit is 0: led_acerto=1, led_erro=0, decrement navios_restantes;
    - else: led_erro=1, led_acerto=0.
  - If the new navios_restantes = 0 → VITORIA. Victory wins when the last attempt is also the last ship.
  - Else if the new tentativas_restantes = 0 → DERROTA.
- ATAQUE display: output bit = 0 only for cells that are attacked AND hold a ship (hits shown).
- VITORIA: led_vitoria=1; display shows the full saved board.
- DERROTA: led_derrota=1; display shows the full saved board.
- Confirm edges are ignored in VITORIA and DERROTA.
- modo=0 in ATAQUE, VITORIA or DERROTA → POSICIONAMENTO next edge.
  - Saved board and salvo are kept.
  - Attack map, status LEDs and tentativas_restantes are cleared.
- Save edges are ignored outside POSICIONAMENTO. Confirm edges are ignored outside ATAQUE.

## Timing
- Edge detection: the block keeps a one-flop history of each button. An edge is button=1 with previous=0; one press yields exactly one action regardless of hold time.
- Latency: an edge sampled at clock edge k updates the map, counters, LEDs and state at edge k. Outputs are valid in cycle k+1.
- Outputs are registered, except coluna*_saida in POSICIONAMENTO, which passes the placement inputs through combinationally.
- Reset values:
  - state DESLIGADO;
  - coluna*_saida = 7'h7F;
  - all LEDs 0;
  - tentativas_restantes 0, navios_restantes 0;
  - saved board 7'h7F per column; salvo 0; button history 0.
- Reset asserted mid-game aborts immediately and restores the reset values.
- Counters never wrap: decrements are blocked at 0.

## Test plan
- Reset, then ligado=1, modo=0 → outputs follow the placement inputs; LEDs 0; counters 0.
- Place ships at (1,1) and (3,4), press save, set modo=1 → navios_restantes=2, tentativas_restantes=15, display 7'h7F on all columns.
- Attack (1,1) → led_acerto=1, navios=1, tentativas=14, coluna1_saida=7'b1111110. Attack (1,1) again → no change.
- Attack (6,2), then (2,0) → ignored. Attack (2,2) → led_erro=1, tentativas=13. Attack (3,4) → led_vitoria=1, coluna3_saida=7'b1110111.
- With MAX_TENTATIVAS=2 and one ship at (5,7): miss, then miss → led_derrota=1, tentativas=0. A further confirm → no change.
- ligado=0 mid-attack → next cycle all outputs 7'h7F, LEDs 0. Then ligado=1, modo=1 without saving → stays in POSICIONAMENTO with display 7'h7F.
